serial_paralelo: RTL and testbench
==================================

SERIAL_PARALELO -- requirements
Module: serial_paralelo

Interface
REQ-001 The block SHALL have parameter COMMA, default 8'hBC, the idle/alignment byte.
REQ-002 The block SHALL have parameter BC_NEEDED, default 4, the number of consecutive aligned COMMA bytes required to declare link active; legal range 1..15.
REQ-003 clk_32f  input  1  bit clock; all state updates on its rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  1  serial bit stream, MSB first, one bit per clk_32f.
REQ-006 data_out  output  8  last completed non-COMMA byte, registered.
REQ-007 valid_out  output  1  data_out holds a received data byte.
REQ-008 active  output  1  byte alignment locked and BC_NEEDED commas seen.
REQ-009 realign_cnt  output  8  count of in-service realignments; present only when SP_REALIGN_EN is defined.

Function
REQ-010 Every cycle the block SHALL shift data_in into an 8-bit shift register at the LSB; the oldest bit sits at the MSB.
REQ-011 The FSM SHALL have states SEARCH, ALIGN and ACTIVE.
REQ-012 A 3-bit phase counter SHALL mark byte boundaries; a byte is complete on the cycle phase wraps from 7 to 0.
REQ-013 SEARCH: each cycle the block SHALL compare the next shift value to COMMA; on a match it SHALL zero the phase, set bc_cnt to 1, and go to ALIGN, or go directly to ACTIVE if BC_NEEDED is 1.
REQ-014 ALIGN: at each byte completion, a COMMA byte SHALL increment bc_cnt, and reaching BC_NEEDED SHALL transition to ACTIVE.
REQ-015 ALIGN: a non-COMMA byte SHALL clear bc_cnt and return to SEARCH.
REQ-016 ACTIVE: at each byte completion, a non-COMMA byte SHALL load data_out and set valid_out to 1.
REQ-017 ACTIVE: at each byte completion, a COMMA byte SHALL clear valid_out and leave data_out unchanged.
REQ-018 Latency SHALL be exactly one clk_32f cycle: data_out and valid_out update on the edge after the byte's last bit is sampled, and hold for 8 cycles until the next byte completes.
REQ-019 active SHALL be 1 exactly while the FSM is in ACTIVE; it SHALL rise on the same edge the FSM enters ACTIVE.
REQ-020 Without SP_REALIGN_EN, ACTIVE SHALL be left only by reset; misaligned commas SHALL be decoded as data.
REQ-021 valid_out SHALL be 0 in SEARCH and ALIGN.

Reset
REQ-022 While reset_L is 0, the block SHALL immediately force: state SEARCH, shift register, phase, bc_cnt, data_out, realign_cnt all 0; valid_out and active 0.
REQ-023 Reset asserted mid-byte SHALL discard the partial byte; after release, alignment SHALL restart from SEARCH.

Configuration
REQ-024 The macro SHALL be named SP_REALIGN_EN.
REQ-025 With SP_REALIGN_EN defined, in ACTIVE the block SHALL check every cycle for COMMA in the shift register; a match at a non-boundary phase SHALL zero the phase, set bc_cnt to 1, clear valid_out and active, move to ALIGN, and increment realign_cnt, saturating at 255.
REQ-026 With SP_REALIGN_EN defined, a COMMA match exactly at a byte boundary SHALL NOT count as a realignment.
REQ-027 With SP_REALIGN_EN undefined, the realign_cnt port and its logic SHALL be absent.

Structure
REQ-028 A shared package phy_pkg SHALL hold the FSM state encoding, the COMMA default (8'hBC) and the BC_NEEDED default, shared with the transmit-side serializer.
REQ-029 Comma detection (shift register plus comparator) SHALL be one sub-module named comma_detect; the FSM and output registers SHALL stay in serial_paralelo.

Verification
REQ-030 Scenario: reset_L=0 for 3 cycles with data_in toggling -> all outputs 0, state SEARCH.
REQ-031 Scenario: 4 x 8'hBC then 8'hA5, 8'h3C, MSB first -> active rises on the edge after the 4th comma's last bit; data_out=8'hA5 with valid_out=1 one cycle after its bit 0, then 8'h3C 8 cycles later.
REQ-032 Scenario: 3 x 8'hBC, then 8'h00, then 4 x 8'hBC -> return to SEARCH after 8'h00; active only after the second comma run.
REQ-033 Scenario: stream preceded by 3 random bits (misaligned start) -> lock on the true comma boundary; later bytes decoded correctly.
REQ-034 Scenario: in ACTIVE, 8'h55 then 8'hBC -> valid_out falls to 0 at the comma boundary while data_out stays 8'h55.
REQ-035 Scenario (SP_REALIGN_EN): in ACTIVE, insert 1 extra bit then commas -> realign_cnt=1, active drops, then re-rises after 4 aligned commas.

Source files
------------

// File: rtl/phy_pkg.sv
// phy_pkg
// Definitions shared by the serial receive path (serial_paralelo) and the
// transmit-side serializer: the receiver FSM state encoding, the default
// idle/alignment byte and the default number of aligned commas needed for lock.
// No ports; import with "import phy_pkg::*;".
package phy_pkg;

    // Receiver alignment states.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } sp_state_t;

    // K28.5-style idle byte transmitted between data bytes and used for alignment.
    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

    // Consecutive aligned commas required before the link is declared active.
    localparam int BC_NEEDED_DEFAULT = 4;

endpackage : phy_pkg

// File: rtl/comma_detect.sv
// comma_detect
// Serial-to-byte shift register plus COMMA comparator for the receive path.
// Every clk_32f edge the incoming bit is shifted in at the LSB, so the oldest
// bit of the current 8-bit window sits at the MSB (MSB-first serial order).
//
// Ports
//   clk_32f    in   bit clock
//   reset_L    in   asynchronous active-low reset, clears the history
//   data_in    in   serial bit, MSB first
//   shift_next out  8-bit shift value including the bit being sampled this edge
//   comma_hit  out  shift_next equals COMMA
module comma_detect
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA = COMMA_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] shift_next,
    output logic       comma_hit
);

    // Only the seven most recent bits need storing: together with the bit on
    // data_in they form the full 8-bit shift value. The bit that would fall
    // off the MSB this edge is never looked at again.
    logic [6:0] history;

    // The FSM decides on the value the register is about to take, which is
    // what gives a one-cycle latency from the last bit to the outputs.
    assign shift_next = {history, data_in};
    assign comma_hit  = (shift_next == COMMA);

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            history <= '0;
        end else begin
            history <= shift_next[6:0];
        end
    end

endmodule : comma_detect

// File: rtl/serial_paralelo.sv
// serial_paralelo
// Serial-to-parallel receiver with comma-based byte alignment. A bit stream
// arriving MSB first on clk_32f is searched for COMMA, byte boundaries are
// locked to it, and once BC_NEEDED consecutive aligned commas have been seen
// the link goes active and every non-comma byte is presented on data_out.
//
// Parameters
//   COMMA      idle/alignment byte (default 8'hBC)
//   BC_NEEDED  aligned commas required for lock, 1..15 (default 4)
//
// Ports
//   clk_32f      in   bit clock, all state changes on its rising edge
//   reset_L      in   asynchronous active-low reset
//   data_in      in   serial bit stream, MSB first
//   data_out     out  last completed non-comma byte (registered)
//   valid_out    out  data_out holds a received data byte
//   active       out  alignment locked and BC_NEEDED commas seen
//   realign_cnt  out  in-service realignments, saturating (SP_REALIGN_EN only)
//
// Build option
//   SP_REALIGN_EN  when defined, a comma seen off the byte boundary while
//                  ACTIVE re-locks the alignment and is counted. When not
//                  defined ACTIVE is left only through reset.
module serial_paralelo
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA     = COMMA_DEFAULT,
    parameter int         BC_NEEDED = BC_NEEDED_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
`ifdef SP_REALIGN_EN
    ,
    output logic [7:0] realign_cnt
`endif
);

    localparam logic [3:0] BC_TARGET = 4'(BC_NEEDED);

    sp_state_t  state, state_next;
    logic [2:0] phase, phase_next;
    logic [3:0] bc_cnt, bc_next, bc_inc;
    logic [7:0] data_next;
    logic       valid_next;
    logic [7:0] shift_next;
    logic       comma_hit;
    logic       byte_done;
`ifdef SP_REALIGN_EN
    logic [7:0] realign_next;
`endif

    comma_detect #(
        .COMMA (COMMA)
    ) u_comma_detect (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .shift_next (shift_next),
        .comma_hit  (comma_hit)
    );

    // A byte completes on the edge where phase wraps from 7 back to 0.
    assign byte_done = (phase == 3'd7);
    assign bc_inc    = bc_cnt + 4'd1;
    assign active    = (state == ACTIVE);

    // Next-state and output decode. phase free-runs; a comma found while
    // searching (or a realignment) restarts it so the following 8 bits
    // form the next byte.
    always_comb begin
        state_next = state;
        phase_next = phase + 3'd1;
        bc_next    = bc_cnt;
        data_next  = data_out;
        valid_next = valid_out;
`ifdef SP_REALIGN_EN
        realign_next = realign_cnt;
`endif
        case (state)
            SEARCH: begin
                valid_next = 1'b0;
                if (comma_hit) begin
                    phase_next = 3'd0;
                    bc_next    = 4'd1;
                    state_next = (BC_TARGET == 4'd1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                valid_next = 1'b0;
                if (byte_done) begin
                    if (comma_hit) begin
                        bc_next = bc_inc;
                        if (bc_inc == BC_TARGET) begin
                            state_next = ACTIVE;
                        end
                    end else begin
                        bc_next    = 4'd0;
                        state_next = SEARCH;
                    end
                end
            end
            ACTIVE: begin
`ifdef SP_REALIGN_EN
                // A comma off the boundary means the alignment slipped:
                // relock on it, treating it as the first comma of a new run.
                if (comma_hit && !byte_done) begin
                    phase_next = 3'd0;
                    bc_next    = 4'd1;
                    valid_next = 1'b0;
                    state_next = ALIGN;
                    if (realign_cnt != 8'hFF) begin
                        realign_next = realign_cnt + 8'd1;
                    end
                end else
`endif
                if (byte_done) begin
                    if (comma_hit) begin
                        valid_next = 1'b0;
                    end else begin
                        data_next  = shift_next;
                        valid_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = SEARCH;
                valid_next = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any partial byte.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= SEARCH;
            phase     <= 3'd0;
            bc_cnt    <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            bc_cnt    <= bc_next;
            data_out  <= data_next;
            valid_out <= valid_next;
        end
    end

`ifdef SP_REALIGN_EN
    // Realignment counter, kept separate so it disappears in the default build.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            realign_cnt <= 8'h00;
        end else begin
            realign_cnt <= realign_next;
        end
    end
`endif

endmodule : serial_paralelo

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo
// Self-checking bench for serial_paralelo. Bits are driven on the falling
// edge and outputs sampled 1 ns after the rising edge. A bit-history model
// tracks the lock position as a bit index and treats bytes as 8-bit windows
// at multiples of 8 bits past it; every cycle the DUT is compared with it,
// plus directed checks at the points of interest of each scenario.
// Honours SP_REALIGN_EN the same way the design does.
module tb_serial_paralelo;

    localparam logic [7:0] COMMA     = 8'hBC;
    localparam int         BC_NEEDED = 4;
    localparam int         M_SEARCH  = 0;
    localparam int         M_ALIGN   = 1;
    localparam int         M_ACTIVE  = 2;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
`ifdef SP_REALIGN_EN
    logic [7:0] realign_cnt;
`endif

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state
    logic       hist[$];
    logic [7:0] m_data;
    logic       m_valid;
    int         m_mode;
    int         m_count;
    int         m_lock;
    int         m_rc;

    serial_paralelo #(
        .COMMA     (COMMA),
        .BC_NEEDED (BC_NEEDED)
    ) dut (
        .clk_32f     (clk_32f),
        .reset_L     (reset_L),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active      (active)
`ifdef SP_REALIGN_EN
        ,
        .realign_cnt (realign_cnt)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        hist.delete();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_mode  = M_SEARCH;
        m_count = 0;
        m_lock  = 0;
        m_rc    = 0;
    endtask

    // Advance the model by one received bit.
    task automatic modelStep(input logic b);
        logic [7:0] win;
        bit         boundary;
        int         n;
        hist.push_back(b);
        n   = hist.size();
        win = 8'h00;
        for (int k = 0; k < 8; k++) begin
            int idx = n - 8 + k;
            win = {win[6:0], (idx >= 0) ? hist[idx] : 1'b0};
        end
        boundary = (m_mode != M_SEARCH) && (((n - m_lock) % 8) == 0);
        if (m_mode == M_SEARCH) begin
            m_valid = 1'b0;
            if (win == COMMA) begin
                m_lock  = n;
                m_count = 1;
                m_mode  = (BC_NEEDED == 1) ? M_ACTIVE : M_ALIGN;
            end
        end else if (m_mode == M_ALIGN) begin
            m_valid = 1'b0;
            if (boundary) begin
                if (win == COMMA) begin
                    m_count++;
                    if (m_count == BC_NEEDED) m_mode = M_ACTIVE;
                end else begin
                    m_count = 0;
                    m_mode  = M_SEARCH;
                end
            end
        end else begin
`ifdef SP_REALIGN_EN
            if (win == COMMA && !boundary) begin
                m_lock  = n;
                m_count = 1;
                m_mode  = M_ALIGN;
                m_valid = 1'b0;
                if (m_rc < 255) m_rc++;
            end else
`endif
            if (boundary) begin
                if (win == COMMA) begin
                    m_valid = 1'b0;
                end else begin
                    m_data  = win;
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".data_out"}, data_out, m_data);
        checkOutput({tag, ".valid_out"}, {7'd0, valid_out}, {7'd0, m_valid});
        checkOutput({tag, ".active"}, {7'd0, active}, {7'd0, (m_mode == M_ACTIVE)});
`ifdef SP_REALIGN_EN
        checkOutput({tag, ".realign_cnt"}, realign_cnt, 8'(m_rc));
`endif
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".data_out"}, data_out, 8'h00);
        checkOutput({tag, ".valid_out"}, {7'd0, valid_out}, 8'h00);
        checkOutput({tag, ".active"}, {7'd0, active}, 8'h00);
`ifdef SP_REALIGN_EN
        checkOutput({tag, ".realign_cnt"}, realign_cnt, 8'h00);
`endif
    endtask

    task automatic applyStimulus(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
        modelStep(b);
        compareAll("cycle");
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(v[i]);
        end
    endtask

    // Assert reset mid-cycle (checks it acts asynchronously), hold it for
    // three cycles with data_in toggling, release just after a rising edge.
    task automatic doReset(input string tag);
        @(negedge clk_32f);
        #2;
        reset_L = 1'b0;
        #1;
        modelReset();
        checkResetState({tag, "_async"});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_32f);
            data_in = ~data_in;
            @(posedge clk_32f);
            #1;
            checkResetState({tag, "_hold"});
        end
        reset_L = 1'b1;
    endtask

    initial begin
        modelReset();

        // Reset with toggling input
        doReset("s1");

        // Four commas, then A5 and 3C
        repeat (4) sendByte(COMMA);
        checkOutput("s2_active", {7'd0, active}, 8'd1);
        checkOutput("s2_valid_idle", {7'd0, valid_out}, 8'd0);
        sendByte(8'hA5);
        checkOutput("s2_data_a5", data_out, 8'hA5);
        checkOutput("s2_valid_a5", {7'd0, valid_out}, 8'd1);
        sendByte(8'h3C);
        checkOutput("s2_data_3c", data_out, 8'h3C);

        // Comma after data: valid drops, data held
        sendByte(8'h55);
        sendByte(COMMA);
        checkOutput("s5_valid", {7'd0, valid_out}, 8'd0);
        checkOutput("s5_data", data_out, 8'h55);

        // Broken comma run returns to search
        doReset("s3");
        repeat (3) sendByte(COMMA);
        sendByte(8'h00);
        checkOutput("s3_after00", {7'd0, active}, 8'd0);
        repeat (3) sendByte(COMMA);
        checkOutput("s3_three", {7'd0, active}, 8'd0);
        sendByte(COMMA);
        checkOutput("s3_four", {7'd0, active}, 8'd1);

        // Misaligned start
        doReset("s4");
        repeat (3) applyStimulus(1'($urandom_range(0, 1)));
        repeat (4) sendByte(COMMA);
        checkOutput("s4_active", {7'd0, active}, 8'd1);
        sendByte(8'h5A);
        checkOutput("s4_data", data_out, 8'h5A);
        checkOutput("s4_valid", {7'd0, valid_out}, 8'd1);

        // Random data bytes against the model
        repeat (40) sendByte(8'($urandom_range(0, 255)));

        // Reset in the middle of a byte
        repeat (3) applyStimulus(1'($urandom_range(0, 1)));
        doReset("s6");
        repeat (4) sendByte(COMMA);
        sendByte(8'h96);
        checkOutput("s6_data", data_out, 8'h96);
        checkOutput("s6_valid", {7'd0, valid_out}, 8'd1);

        // One extra bit, then commas
        applyStimulus(1'b0);
        sendByte(COMMA);
`ifdef SP_REALIGN_EN
        checkOutput("s7_realign", realign_cnt, 8'd1);
        checkOutput("s7_dropped", {7'd0, active}, 8'd0);
        repeat (3) sendByte(COMMA);
        checkOutput("s7_relock", {7'd0, active}, 8'd1);
        sendByte(8'h81);
        checkOutput("s7_data", data_out, 8'h81);
`else
        checkOutput("s7_still_active", {7'd0, active}, 8'd1);
        checkOutput("s7_slipped_data", data_out, 8'h5E);
        repeat (3) sendByte(COMMA);
        checkOutput("s7_hold_active", {7'd0, active}, 8'd1);
`endif
        repeat (10) sendByte(8'($urandom_range(0, 255)));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule : tb_serial_paralelo
